// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: parses host read/write packets from UART bytes and runs one 32-bit req/ack bus transaction each
module uart_bus_bridge #(
    parameter int RX_TIMEOUT  = 1000000,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_received,
    input  logic [7:0]  uart_rx_byte,
    input  logic        uart_recv_error,
    output logic        uart_transmit,
    output logic [7:0]  uart_tx_byte,
    input  logic        uart_is_transmitting,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        rx_overrun
);
    localparam int RW = $clog2(RX_TIMEOUT + 1);
    localparam int BW = $clog2(BUS_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP, RESP_WAIT} state_t;
    state_t state, state_n;
    logic [RW-1:0] rx_timer;
    logic [BW-1:0] bus_timer;
    logic [1:0]    cnt;
    logic [31:0]   resp;
    logic [2:0]    resp_left;
    logic          rx_ok, in_pkt, rx_expire, bus_expire, is_op;
    assign rx_ok      = uart_received && !uart_recv_error;
    assign in_pkt     = state == ADDR || state == WDATA;
    assign rx_expire  = in_pkt && !uart_received && rx_timer == RW'(RX_TIMEOUT - 1);
    assign bus_expire = bus_timer == BW'(BUS_TIMEOUT - 1);
    assign is_op      = uart_rx_byte == 8'h57 || uart_rx_byte == 8'h52;
    assign bus_req    = state == BUS;
    assign busy       = state != IDLE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (rx_ok) state_n = is_op ? ADDR : RESP;
            ADDR:      if (uart_recv_error || rx_expire) state_n = IDLE;
                       else if (rx_ok && cnt == 2'd3) state_n = bus_we ? WDATA : BUS;
            WDATA:     if (uart_recv_error || rx_expire) state_n = IDLE;
                       else if (rx_ok && cnt == 2'd3) state_n = BUS;
            BUS:       if (bus_ack || bus_expire) state_n = RESP;
            RESP:      if (!uart_is_transmitting) state_n = RESP_WAIT;
            // cnt==2 skips the pulse cycle and the cycle before the UART reports busy
            RESP_WAIT: if (cnt == 2'd2 && !uart_is_transmitting) state_n = resp_left != 3'd0 ? RESP : IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
            bus_we        <= 1'b0;
            bus_addr      <= 32'h0;
            bus_wdata     <= 32'h0;
            rx_overrun    <= 1'b0;
            rx_timer      <= '0;
            bus_timer     <= '0;
            cnt           <= 2'd0;
            resp          <= 32'h0;
            resp_left     <= 3'd0;
        end else begin
            state         <= state_n;
            uart_transmit <= 1'b0;
            rx_overrun    <= rx_ok && (state == BUS || state == RESP || state == RESP_WAIT);
            rx_timer      <= (uart_received || !in_pkt) ? '0 : rx_timer + 1'b1;
            bus_timer     <= state == BUS ? bus_timer + 1'b1 : '0;
            case (state)
                IDLE: if (rx_ok) begin
                    bus_we    <= uart_rx_byte == 8'h57;
                    cnt       <= 2'd0;
                    resp      <= {8'h3F, 24'h0};
                    resp_left <= 3'd1;
                end
                ADDR: if (rx_ok) begin
                    bus_addr <= {bus_addr[23:0], uart_rx_byte};
                    cnt      <= cnt + 2'd1;
                end
                WDATA: if (rx_ok) begin
                    bus_wdata <= {bus_wdata[23:0], uart_rx_byte};
                    cnt       <= cnt + 2'd1;
                end
                BUS: if (bus_ack) begin
                    resp      <= bus_we ? {8'h4B, 24'h0} : bus_rdata;
                    resp_left <= bus_we ? 3'd1 : 3'd4;
                end else if (bus_expire) begin
                    resp      <= {8'h45, 24'h0};
                    resp_left <= 3'd1;
                end
                RESP: if (!uart_is_transmitting) begin
                    uart_transmit <= 1'b1;
                    uart_tx_byte  <= resp[31:24];
                    resp          <= {resp[23:0], 8'h00};
                    resp_left     <= resp_left - 3'd1;
                    cnt           <= 2'd0;
                end
                RESP_WAIT: if (cnt != 2'd2) cnt <= cnt + 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: randomized packets against a packet-level model of host, UART and bus
module tb_uart_bus_bridge;
    logic        clk = 1'b0, rst = 1'b1;
    logic        uart_received = 1'b0, uart_recv_error = 1'b0, uart_is_transmitting = 1'b0;
    logic [7:0]  uart_rx_byte = 8'h00;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        uart_transmit, bus_req, bus_we, busy, rx_overrun;
    logic [7:0]  uart_tx_byte;
    logic [31:0] bus_addr, bus_wdata;

    uart_bus_bridge #(.RX_TIMEOUT(100), .BUS_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .uart_received(uart_received), .uart_rx_byte(uart_rx_byte), .uart_recv_error(uart_recv_error),
        .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte), .uart_is_transmitting(uart_is_transmitting),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [15:0] len;} txn_t;
    int          passed = 0, total = 0;
    logic [7:0]  tx_q[$], pkt[$];
    txn_t        txns[$];
    txn_t        cur;
    logic        in_req = 1'b0;
    int          req_len = 0, ack_after = -1, pend = 0, busy_left = 0;
    int          ovr_cnt = 0, tx_viol = 0, stab_err = 0;
    logic [31:0] rdata_cfg = 32'h0;

    // One clock: observe outputs just after the edge, then advance the UART and bus models
    task automatic tick();
        @(posedge clk);
        #1;
        if (uart_transmit) begin
            tx_q.push_back(uart_tx_byte);
            if (uart_is_transmitting || pend != 0) tx_viol++;
        end
        if (rx_overrun) ovr_cnt++;
        if (uart_transmit) pend = 2;
        else if (pend != 0) begin
            pend--;
            if (pend == 0) begin
                uart_is_transmitting = 1'b1;
                busy_left = $urandom_range(2, 6);
            end
        end else if (uart_is_transmitting) begin
            busy_left--;
            if (busy_left <= 0) uart_is_transmitting = 1'b0;
        end
        if (bus_req) begin
            if (!in_req) begin
                in_req = 1'b1;
                req_len = 0;
                cur = '{we: bus_we, addr: bus_addr, wdata: bus_wdata, len: 16'h0};
            end else if ({bus_we, bus_addr, bus_wdata} !== {cur.we, cur.addr, cur.wdata}) stab_err++;
            req_len++;
            bus_ack = ack_after >= 0 && req_len == ack_after + 1;
        end else begin
            if (in_req) begin
                cur.len = 16'(req_len);
                txns.push_back(cur);
                in_req = 1'b0;
            end
            bus_ack = 1'b0;
        end
        bus_rdata = bus_ack ? rdata_cfg : $urandom;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_received = 1'b1;
        uart_rx_byte = b;
        tick();
        uart_received = 1'b0;
    endtask

    task automatic clear();
        tx_q.delete();
        txns.delete();
        ovr_cnt = 0;
        tx_viol = 0;
        stab_err = 0;
    endtask

    task automatic build_pkt(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        pkt.delete();
        pkt.push_back(op);
        for (int i = 3; i >= 0; i--) pkt.push_back(a[8*i +: 8]);
        if (op == 8'h57) for (int i = 3; i >= 0; i--) pkt.push_back(d[8*i +: 8]);
    endtask

    task automatic run_pkt(output bit done, output logic req_seen);
        for (int i = 0; i < pkt.size(); i++) begin
            if (i > 0) repeat ($urandom_range(0, 3)) tick();
            send_byte(pkt[i]);
        end
        req_seen = bus_req;
        for (int i = 0; i < 4000 && busy; i++) tick();
        done = !busy;
    endtask

    function automatic logic [47:0] pack_tx();
        logic [47:0] r;
        r = '0;
        r[47:40] = 8'(tx_q.size());
        for (int i = 0; i < tx_q.size() && i < 5; i++) r[39-8*i -: 8] = tx_q[i];
        return r;
    endfunction

    function automatic logic [56:0] pack_txn();
        if (txns.size() == 0) return '0;
        return {8'(txns.size()), txns[0].we, txns[0].addr, txns[0].len};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if ({uart_transmit, uart_tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy, rx_overrun} !== 77'd0)
            $display("FAIL reset_outputs: got %h want 0", {uart_transmit, uart_tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy, rx_overrun}); else passed++;
        rst = 1'b0;
        repeat (2) tick();
        total++; if ({uart_transmit, bus_req, busy, rx_overrun} !== 4'd0)
            $display("FAIL after_reset_idle: got %b want 0000", {uart_transmit, bus_req, busy, rx_overrun}); else passed++;
    endtask

    task automatic test_write();
        logic [31:0] a, d;
        int ack;
        bit done;
        logic rq;
        for (int n = 0; n < 5; n++) begin
            a = n == 0 ? 32'h00001004 : $urandom;
            d = n == 0 ? 32'hDEADBEEF : $urandom;
            ack = n == 0 ? 3 : $urandom_range(0, 12);
            build_pkt(8'h57, a, d);
            clear();
            ack_after = ack;
            run_pkt(done, rq);
            total++; if (!(done && rq === 1'b1)) $display("FAIL write_flow: done=%0d req_after_last=%b want 1 1", done, rq); else passed++;
            total++; if (pack_txn() !== {8'd1, 1'b1, a, 16'(ack + 1)}) $display("FAIL write_txn: got %h want %h", pack_txn(), {8'd1, 1'b1, a, 16'(ack + 1)}); else passed++;
            total++; if (txns.size() == 0 || txns[0].wdata !== d) $display("FAIL write_wdata: got %h want %h", txns.size() ? txns[0].wdata : 32'h0, d); else passed++;
            total++; if (pack_tx() !== {8'd1, 8'h4B, 32'h0}) $display("FAIL write_tx: got %h want %h", pack_tx(), {8'd1, 8'h4B, 32'h0}); else passed++;
            total++; if (stab_err + tx_viol != 0) $display("FAIL write_protocol: stab_err=%0d tx_viol=%0d want 0 0", stab_err, tx_viol); else passed++;
        end
    endtask

    task automatic test_read();
        logic [31:0] a, r;
        int ack;
        bit done;
        logic rq;
        for (int n = 0; n < 5; n++) begin
            a = n == 0 ? 32'h80000000 : $urandom;
            r = n == 0 ? 32'h12345678 : $urandom;
            ack = $urandom_range(0, 12);
            build_pkt(8'h52, a, 32'h0);
            clear();
            ack_after = ack;
            rdata_cfg = r;
            run_pkt(done, rq);
            total++; if (!(done && rq === 1'b1)) $display("FAIL read_flow: done=%0d req_after_last=%b want 1 1", done, rq); else passed++;
            total++; if (pack_txn() !== {8'd1, 1'b0, a, 16'(ack + 1)}) $display("FAIL read_txn: got %h want %h", pack_txn(), {8'd1, 1'b0, a, 16'(ack + 1)}); else passed++;
            total++; if (pack_tx() !== {8'd4, r, 8'h00}) $display("FAIL read_tx: got %h want %h", pack_tx(), {8'd4, r, 8'h00}); else passed++;
            total++; if (stab_err + tx_viol != 0) $display("FAIL read_protocol: stab_err=%0d tx_viol=%0d want 0 0", stab_err, tx_viol); else passed++;
        end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] b;
        bit done;
        logic rq;
        for (int n = 0; n < 3; n++) begin
            b = 8'h41;
            if (n > 0) do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
            pkt.delete();
            pkt.push_back(b);
            clear();
            run_pkt(done, rq);
            total++; if (!done || pack_tx() !== {8'd1, 8'h3F, 32'h0}) $display("FAIL bad_opcode_tx: byte=%h got %h want %h", b, pack_tx(), {8'd1, 8'h3F, 32'h0}); else passed++;
            total++; if (pack_txn() !== 57'd0) $display("FAIL bad_opcode_nobus: got %h want 0", pack_txn()); else passed++;
        end
    endtask

    task automatic test_bus_timeout();
        logic [31:0] a, r;
        logic we;
        int ack;
        bit done;
        logic rq;
        logic [47:0] exp_tx;
        for (int n = 0; n < 3; n++) begin
            we = n == 1;
            ack = n == 2 ? 254 : -1;
            a = $urandom;
            r = $urandom;
            build_pkt(we ? 8'h57 : 8'h52, a, $urandom);
            clear();
            ack_after = ack;
            rdata_cfg = r;
            run_pkt(done, rq);
            exp_tx = ack < 0 ? {8'd1, 8'h45, 32'h0} : {8'd4, r, 8'h00};
            total++; if (pack_txn() !== {8'd1, we, a, 16'd255}) $display("FAIL bus_timeout_txn: got %h want %h", pack_txn(), {8'd1, we, a, 16'd255}); else passed++;
            total++; if (!done || pack_tx() !== exp_tx) $display("FAIL bus_timeout_tx: got %h want %h", pack_tx(), exp_tx); else passed++;
        end
    endtask

    task automatic test_rx_timeout();
        logic [31:0] a, r;
        bit done;
        logic rq;
        clear();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (90) tick();
        total++; if (busy !== 1'b1) $display("FAIL rx_timeout_early: busy=%b want 1", busy); else passed++;
        repeat (15) tick();
        total++; if (busy !== 1'b0) $display("FAIL rx_timeout_idle: busy=%b want 0", busy); else passed++;
        total++; if ({pack_tx(), pack_txn()} !== 105'd0) $display("FAIL rx_timeout_silent: tx=%h txn=%h want 0 0", pack_tx(), pack_txn()); else passed++;
        a = $urandom;
        r = $urandom;
        build_pkt(8'h52, a, 32'h0);
        ack_after = 2;
        rdata_cfg = r;
        run_pkt(done, rq);
        total++; if (!done || pack_tx() !== {8'd4, r, 8'h00} || pack_txn() !== {8'd1, 1'b0, a, 16'd3})
            $display("FAIL rx_timeout_recover: tx=%h txn=%h want %h %h", pack_tx(), pack_txn(), {8'd4, r, 8'h00}, {8'd1, 1'b0, a, 16'd3}); else passed++;
    endtask

    task automatic test_recv_error();
        clear();
        send_byte(8'h57);
        send_byte(8'hA3);
        send_byte(8'hA2);
        uart_recv_error = 1'b1;
        tick();
        uart_recv_error = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL recv_error_idle: busy=%b want 0", busy); else passed++;
        send_byte(8'h52);
        uart_recv_error = 1'b1;
        send_byte(8'h11);
        uart_recv_error = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL recv_error_with_byte: busy=%b want 0", busy); else passed++;
        repeat (20) tick();
        total++; if ({pack_tx(), pack_txn()} !== 105'd0) $display("FAIL recv_error_silent: tx=%h txn=%h want 0 0", pack_tx(), pack_txn()); else passed++;
    endtask

    task automatic test_overrun();
        logic [31:0] a, r;
        int i;
        a = $urandom;
        r = $urandom;
        build_pkt(8'h52, a, 32'h0);
        clear();
        ack_after = 1;
        rdata_cfg = r;
        foreach (pkt[k]) send_byte(pkt[k]);
        for (i = 0; i < 2000 && !uart_transmit; i++) tick();
        total++; if (!uart_transmit) $display("FAIL overrun_first_tx: no transmit within %0d cycles", i); else passed++;
        send_byte(8'h57);
        for (i = 0; i < 2000 && busy; i++) tick();
        repeat (5) tick();
        total++; if (ovr_cnt != 1) $display("FAIL overrun_pulse: got %0d pulses want 1", ovr_cnt); else passed++;
        total++; if (pack_tx() !== {8'd4, r, 8'h00} || busy !== 1'b0) $display("FAIL overrun_resp: tx=%h busy=%b want %h 0", pack_tx(), busy, {8'd4, r, 8'h00}); else passed++;
    endtask

    task automatic test_reset_in_bus();
        logic [31:0] a, d;
        bit done;
        logic rq;
        build_pkt(8'h57, $urandom, $urandom);
        clear();
        ack_after = -1;
        foreach (pkt[k]) send_byte(pkt[k]);
        repeat (5) tick();
        total++; if (bus_req !== 1'b1) $display("FAIL rst_bus_pre: bus_req=%b want 1", bus_req); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({uart_transmit, uart_tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy, rx_overrun} !== 77'd0)
            $display("FAIL rst_bus_outputs: got %h want 0", {uart_transmit, uart_tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy, rx_overrun}); else passed++;
        repeat (20) tick();
        total++; if (tx_q.size() != 0) $display("FAIL rst_bus_no_tx: got %0d bytes want 0", tx_q.size()); else passed++;
        a = $urandom;
        d = $urandom;
        build_pkt(8'h57, a, d);
        clear();
        ack_after = 0;
        run_pkt(done, rq);
        total++; if (!done || pack_tx() !== {8'd1, 8'h4B, 32'h0} || pack_txn() !== {8'd1, 1'b1, a, 16'd1} || txns[0].wdata !== d)
            $display("FAIL rst_bus_recover: tx=%h txn=%h want %h %h", pack_tx(), pack_txn(), {8'd1, 8'h4B, 32'h0}, {8'd1, 1'b1, a, 16'd1}); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d, r;
        int kind;
        bit done;
        logic rq;
        logic [47:0] exp_tx;
        logic [56:0] exp_txn;
        for (int n = 0; n < 8; n++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            d = $urandom;
            r = $urandom;
            ack_after = $urandom_range(0, 6);
            rdata_cfg = r;
            if (kind == 2) begin
                pkt.delete();
                pkt.push_back(8'h00);
            end else build_pkt(kind == 0 ? 8'h57 : 8'h52, a, d);
            clear();
            run_pkt(done, rq);
            exp_tx = kind == 0 ? {8'd1, 8'h4B, 32'h0} : kind == 1 ? {8'd4, r, 8'h00} : {8'd1, 8'h3F, 32'h0};
            exp_txn = kind == 2 ? 57'd0 : {8'd1, kind == 0, a, 16'(ack_after + 1)};
            total++; if (!done || pack_tx() !== exp_tx || pack_txn() !== exp_txn || tx_viol != 0)
                $display("FAIL b2b_%0d kind=%0d: tx=%h txn=%h viol=%0d want %h %h 0", n, kind, pack_tx(), pack_txn(), tx_viol, exp_tx, exp_txn); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_bus_timeout();
        test_rx_timeout();
        test_recv_error();
        test_overrun();
        test_reset_in_bus();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Byte-level command responder on the parallel side of the io_hub UART.
- Takes received bytes (received/rx_byte/recv_error), parses host read/write packets and runs one 32-bit transaction on a simple req/ack bus.
- Returns response bytes through the UART transmit handshake (transmit/tx_byte/is_transmitting).
- Gives a serial host debug access to the system address space.

Parameters:
- RX_TIMEOUT, 1000000: clk cycles allowed between bytes of one packet before the partial packet is discarded.
- BUS_TIMEOUT, 255: clk cycles allowed for bus_ack after bus_req rises.

Ports:
- clk  input  1  master clock
- rst  input  1  synchronous reset, active-high
- uart_received  input  1  one-cycle pulse: uart_rx_byte is valid
- uart_rx_byte  input  8  received byte
- uart_recv_error  input  1  one-cycle pulse: framing error on the serial line
- uart_transmit  output  1  one-cycle pulse: send uart_tx_byte
- uart_tx_byte  output  8  byte to send; held stable from the pulse until the next pulse
- uart_is_transmitting  input  1  UART transmitter busy
- bus_req  output  1  transaction request; held until bus_ack or timeout
- bus_we  output  1  1 = write, 0 = read; stable while bus_req=1
- bus_addr  output  32  byte address; stable while bus_req=1
- bus_wdata  output  32  write data; stable while bus_req=1
- bus_ack  input  1  transaction complete; ignored when bus_req=0
- bus_rdata  input  32  read data; valid in the cycle bus_ack=1
- busy  output  1  high in every state except IDLE
- rx_overrun  output  1  one-cycle pulse: a byte arrived while in BUS, RESP or RESP_WAIT and was dropped

Behaviour:
- Reset: state=IDLE; every output 0 (uart_tx_byte=0, bus_addr=0, bus_wdata=0). Reset mid-packet or mid-transaction abandons it immediately; bus_req drops the following cycle.
- Packet format, all fields MSB first:
  - Write: 0x57, A3, A2, A1, A0, D3, D2, D1, D0.
  - Read: 0x52, A3, A2, A1, A0.
- IDLE: on uart_received:
  - 0x57 → ADDR with we=1.
  - 0x52 → ADDR with we=0.
  - Any other byte → RESP with response 0x3F (1 byte).
- ADDR: each received byte shifts into bus_addr from the LSB side (bus_addr <= {bus_addr[23:0], byte}). A 2-bit byte counter counts the bytes. After the 4th byte: WDATA if we=1, else BUS.
- WDATA: same shifting into bus_wdata. After the 4th byte → BUS.
- BUS: bus_req=1 starting the cycle after entry.
  - bus_ack=1 with bus_req=1 → bus_req=0 the next cycle.
  - Read response: the 4 bytes of bus_rdata, MSB first, captured in the ack cycle.
  - Write response: 0x4B.
  - BUS_TIMEOUT cycles without bus_ack → bus_req=0; response 0x45 (1 byte, read or write).
  - An ack arriving in the same cycle the timeout expires counts as success.
- RESP: when uart_is_transmitting=0:
  - Drive uart_tx_byte and pulse uart_transmit for exactly 1 cycle.
  - Go to RESP_WAIT.
- RESP_WAIT:
  - Ignore the first cycle after the pulse (the UART raises is_transmitting one cycle late).
  - Then wait for uart_is_transmitting=0.
  - More bytes remaining → RESP; otherwise → IDLE.
- Inter-byte timer:
  - Reset on every uart_received.
  - Counts only in ADDR and WDATA.
  - Reaching RX_TIMEOUT → IDLE silently, with no response.
- uart_recv_error in ADDR or WDATA → IDLE silently. In any other state it is ignored.
- Byte and error in the same cycle: the error wins and the byte is discarded.
- uart_received in BUS, RESP or RESP_WAIT: the byte is dropped and rx_overrun pulses for 1 cycle.
- No pipelining: one outstanding packet at a time.
- Latency: bus_req rises 1 cycle after the last packet byte. The first uart_transmit is ≥1 cycle after the bus_ack cycle.

Test Plan:
- Write: bytes 57 00 00 10 04 DE AD BE EF; bus_ack 3 cycles after bus_req → one transaction with bus_we=1, bus_addr=0x00001004, bus_wdata=0xDEADBEEF; single tx byte 0x4B; busy=0 afterwards.
- Read: 52 80 00 00 00; bus_rdata=0x12345678 with ack → tx bytes 12 34 56 78 in order; each uart_transmit pulse waits for uart_is_transmitting to fall.
- Bad opcode 0x41 → tx 0x3F, no bus_req. Then 52 + addr with bus_ack never asserted → bus_req drops after 255 cycles; tx 0x45.
- Partial packet 57 00 00, then silence for RX_TIMEOUT (override to 100) → IDLE, busy=0, no tx. A following full read completes normally.
- uart_recv_error after 2 address bytes → IDLE, no tx. A byte arriving while in RESP_WAIT → rx_overrun pulse, and the response is unaffected.
- rst asserted for 1 cycle during BUS → bus_req=0 next cycle, all outputs 0, no tx. A following write works.
